// File: rtl/vga_timing_param_if.sv
// Pixel-request bus: the timing core publishes the coordinate, the source returns its colour.
// Latency/backpressure: none; colour must be valid while the coordinate is driven.
interface vga_timing_param_if #(
    parameter int COLOR_W = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
);
    logic               pix_req;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_r;
    logic [COLOR_W-1:0] pix_g;
    logic [COLOR_W-1:0] pix_b;

    modport master (
        output pix_req, pix_x, pix_y,
        input  pix_r, pix_g, pix_b
    );

    modport slave (
        input  pix_req, pix_x, pix_y,
        output pix_r, pix_g, pix_b
    );
endinterface

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator with pixel-request bus and built-in test patterns.
// Latency: pins lag pix_x/pix_y by one pixel period (CLK_DIV clks); backpressure: none, free-running.
module vga_timing_param #(
    parameter int   CLK_DIV    = 2,
    parameter int   COLOR_W    = 4,
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HSYNC_POL  = 1'b0,
    parameter logic VSYNC_POL  = 1'b0,
    parameter int   X_W        = 10,
    parameter int   Y_W        = 10,
    parameter int   CHECK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               resetbutton,
    input  logic [1:0]         mode,
    vga_timing_param_if.master pix,
    output logic [COLOR_W-1:0] vga_red,
    output logic [COLOR_W-1:0] vga_green,
    output logic [COLOR_W-1:0] vga_blue,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   divcnt;
    logic               pe;
    logic [X_W-1:0]     hcnt;
    logic [Y_W-1:0]     vcnt;
    logic [1:0]         mode_q;
    logic               origin;
    logic               active;
    logic [2:0]         bar;
    logic               hs_nxt;
    logic               vs_nxt;
    logic [COLOR_W-1:0] r_nxt;
    logic [COLOR_W-1:0] g_nxt;
    logic [COLOR_W-1:0] b_nxt;

    // With CLK_DIV=1 divcnt never leaves 0, so pe is held high.
    assign pe     = (divcnt == DIV_W'(CLK_DIV - 1));
    assign origin = (hcnt == '0) && (vcnt == '0);
    assign active = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);

    assign pix.pix_x   = hcnt;
    assign pix.pix_y   = vcnt;
    assign pix.pix_req = active;

    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            divcnt <= '0;
        end else if (pe) begin
            divcnt <= '0;
        end else begin
            divcnt <= divcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            hcnt   <= '0;
            vcnt   <= '0;
            mode_q <= 2'd0;
        end else if (pe) begin
            if (hcnt == X_W'(H_TOTAL - 1)) begin
                hcnt <= '0;
                if (vcnt == Y_W'(V_TOTAL - 1)) begin
                    vcnt <= '0;
                end else begin
                    vcnt <= vcnt + 1'b1;
                end
            end else begin
                hcnt <= hcnt + 1'b1;
            end
            // Pattern only switches on a frame boundary to avoid a torn frame.
            if (origin) begin
                mode_q <= mode;
            end
        end
    end

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(hcnt) >= k * BAR_W) begin
                bar = 3'(k);
            end
        end
    end

    always_comb begin
        hs_nxt = ((int'(hcnt) >= HS_START) && (int'(hcnt) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vs_nxt = ((int'(vcnt) >= VS_START) && (int'(vcnt) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        r_nxt  = '0;
        g_nxt  = '0;
        b_nxt  = '0;
        if (active) begin
            case (mode_q)
                2'd0: begin
                    r_nxt = pix.pix_r;
                    g_nxt = pix.pix_g;
                    b_nxt = pix.pix_b;
                end
                2'd1: begin
                    r_nxt = {COLOR_W{~bar[1]}};
                    g_nxt = {COLOR_W{~bar[2]}};
                    b_nxt = {COLOR_W{~bar[0]}};
                end
                2'd2: begin
                    if (hcnt[CHECK_LOG2] ^ vcnt[CHECK_LOG2]) begin
                        r_nxt = '1;
                        g_nxt = '1;
                        b_nxt = '1;
                    end
                end
                default: begin
                    r_nxt = hcnt[COLOR_W+3:4];
                    g_nxt = vcnt[COLOR_W+3:4];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetbutton) begin
        if (!resetbutton) begin
            vga_red     <= '0;
            vga_green   <= '0;
            vga_blue    <= '0;
            vga_hsync   <= ~HSYNC_POL;
            vga_vsync   <= ~VSYNC_POL;
            frame_start <= 1'b0;
        end else begin
            // Evaluated every clk so the pulse is one clk wide whatever CLK_DIV is.
            frame_start <= pe && origin;
            if (pe) begin
                vga_red   <= r_nxt;
                vga_green <= g_nxt;
                vga_blue  <= b_nxt;
                vga_hsync <= hs_nxt;
                vga_vsync <= vs_nxt;
            end
        end
    end
endmodule
